// File: rtl/vga_timing_pkg.sv
// Shared region encodings, 640x480@60 timing constants and the registered output bundle
// used by the VGA timing generator, the colour-lookup stage and the display top.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_BACK   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_FRONT  = 2'd3
   } region_t;

   localparam int unsigned H_SYNC_LEN   = 96;
   localparam int unsigned H_BACK_LEN   = 48;
   localparam int unsigned H_ACTIVE_LEN = 640;
   localparam int unsigned H_FRONT_LEN  = 16;

   localparam int unsigned V_SYNC_LEN   = 2;
   localparam int unsigned V_BACK_LEN   = 33;
   localparam int unsigned V_ACTIVE_LEN = 480;
   localparam int unsigned V_FRONT_LEN  = 10;

   localparam int unsigned CELL_W_LEN   = 80;
   localparam int unsigned CELL_H_LEN   = 60;

   localparam int unsigned CNT_W        = 10;
   localparam int unsigned MAX_CELLS    = 8;

   typedef struct packed {
      logic             hs;
      logic             vs;
      logic [1:0]       h_state;
      logic [1:0]       v_state;
      logic             disp_en;
      logic [CNT_W-1:0] pix_x;
      logic [CNT_W-1:0] pix_y;
      logic [2:0]       cell_x;
      logic [2:0]       cell_y;
      logic             frame_start;
   } vga_out_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter, region decode, active coordinate and an incremental
// colour-cell index that tracks the counter without a divider.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned SYNC_LEN   = H_SYNC_LEN,
   parameter int unsigned BACK_LEN   = H_BACK_LEN,
   parameter int unsigned ACTIVE_LEN = H_ACTIVE_LEN,
   parameter int unsigned FRONT_LEN  = H_FRONT_LEN,
   parameter int unsigned CELL_LEN   = CELL_W_LEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_i,
   output logic [CNT_W-1:0] count_o,
   output logic [1:0]       region_o,
   output logic             wrap_o,
   output logic [CNT_W-1:0] coord_o,
   output logic [2:0]       cell_o
);

   localparam int unsigned TOTAL = SYNC_LEN + BACK_LEN + ACTIVE_LEN + FRONT_LEN;

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_LEN);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC_LEN + BACK_LEN);
   localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC_LEN + BACK_LEN + ACTIVE_LEN);
   localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CELL_LEN - 1);
   localparam logic [2:0]       CELL_MAX  = 3'(MAX_CELLS - 1);

   if (ACTIVE_LEN % CELL_LEN != 0) begin : g_bad_cell_size
      $error("vga_axis_counter: ACTIVE_LEN must be a multiple of CELL_LEN");
   end
   if (ACTIVE_LEN / CELL_LEN > MAX_CELLS) begin : g_too_many_cells
      $error("vga_axis_counter: more than 8 cells on one axis");
   end
   if (TOTAL > (1 << CNT_W)) begin : g_total_too_large
      $error("vga_axis_counter: axis total does not fit the counter width");
   end

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] sub_q, sub_d;
   logic [2:0]       cell_q, cell_d;
   logic [CNT_W-1:0] count_next;
   logic             in_active;
   region_t          region;

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values and simulation matches the synthesised hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         sub_q   <= '0;
         cell_q  <= '0;
      end else begin
         count_q <= count_d;
         sub_q   <= sub_d;
         cell_q  <= cell_d;
      end
   end

   // NOTE: every variable gets a default at the top of the block; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      count_d    = count_q;
      sub_d      = sub_q;
      cell_d     = cell_q;
      wrap_o     = (count_q == LAST);
      count_next = wrap_o ? '0 : count_q + 1'b1;
      in_active  = (count_q >= ACT_START) && (count_q < ACT_END);

      if (step_i) begin
         count_d = count_next;
         if (count_next == ACT_START) begin
            sub_d  = '0;
            cell_d = '0;
         end else if (in_active && (count_next < ACT_END)) begin
            if (sub_q == CELL_LAST) begin
               sub_d  = '0;
               cell_d = (cell_q == CELL_MAX) ? CELL_MAX : cell_q + 3'd1;
            end else begin
               sub_d  = sub_q + 1'b1;
            end
         end else begin
            sub_d  = '0;
            cell_d = '0;
         end
      end
   end

   always_comb begin
      region = ST_FRONT;
      if (count_q < SYNC_END) begin
         region = ST_SYNC;
      end else if (count_q < ACT_START) begin
         region = ST_BACK;
      end else if (count_q < ACT_END) begin
         region = ST_ACTIVE;
      end
   end

   assign count_o  = count_q;
   assign region_o = region;
   assign coord_o  = in_active ? (count_q - ACT_START) : '0;
   assign cell_o   = cell_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 timing generator: /2 pixel enable from CLOCK_50, chained H/V axis counters
// and a registered output stage one clock behind the counters.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = H_SYNC_LEN,
   parameter int unsigned H_BACK   = H_BACK_LEN,
   parameter int unsigned H_ACTIVE = H_ACTIVE_LEN,
   parameter int unsigned H_FRONT  = H_FRONT_LEN,
   parameter int unsigned V_SYNC   = V_SYNC_LEN,
   parameter int unsigned V_BACK   = V_BACK_LEN,
   parameter int unsigned V_ACTIVE = V_ACTIVE_LEN,
   parameter int unsigned V_FRONT  = V_FRONT_LEN,
   parameter int unsigned CELL_W   = CELL_W_LEN,
   parameter int unsigned CELL_H   = CELL_H_LEN,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   output logic       PIX_EN,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [1:0] H_STATE,
   output logic [1:0] V_STATE,
   output logic       DISP_EN,
   output logic [9:0] PIX_X,
   output logic [9:0] PIX_Y,
   output logic [2:0] CELL_X,
   output logic [2:0] CELL_Y,
   output logic       FRAME_START
);

   localparam vga_out_t OUT_RST = '{
      hs: ~SYNC_POL, vs: ~SYNC_POL, h_state: 2'd0, v_state: 2'd0, disp_en: 1'b0,
      pix_x: '0, pix_y: '0, cell_x: 3'd0, cell_y: 3'd0, frame_start: 1'b0
   };

   logic             pix_en_q;
   logic             v_step;
   logic             h_wrap;
   logic             v_wrap_unused;
   logic [CNT_W-1:0] h_count, v_count;
   logic [CNT_W-1:0] h_coord, v_coord;
   logic [1:0]       h_region, v_region;
   logic [2:0]       h_cell, v_cell;
   vga_out_t         out_d, out_q;

   assign v_step = pix_en_q & h_wrap;

   vga_axis_counter #(
      .SYNC_LEN   (H_SYNC),
      .BACK_LEN   (H_BACK),
      .ACTIVE_LEN (H_ACTIVE),
      .FRONT_LEN  (H_FRONT),
      .CELL_LEN   (CELL_W)
   ) u_h_axis (
      .clk      (CLOCK_50),
      .rst_n    (RESET_N),
      .step_i   (pix_en_q),
      .count_o  (h_count),
      .region_o (h_region),
      .wrap_o   (h_wrap),
      .coord_o  (h_coord),
      .cell_o   (h_cell)
   );

   vga_axis_counter #(
      .SYNC_LEN   (V_SYNC),
      .BACK_LEN   (V_BACK),
      .ACTIVE_LEN (V_ACTIVE),
      .FRONT_LEN  (V_FRONT),
      .CELL_LEN   (CELL_H)
   ) u_v_axis (
      .clk      (CLOCK_50),
      .rst_n    (RESET_N),
      .step_i   (v_step),
      .count_o  (v_count),
      .region_o (v_region),
      .wrap_o   (v_wrap_unused),
      .coord_o  (v_coord),
      .cell_o   (v_cell)
   );

   // (0,0) is held for two clocks; pix_en_q is low only on the first of them.
   always_comb begin
      out_d             = OUT_RST;
      out_d.hs          = (h_region == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      out_d.vs          = (v_region == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      out_d.h_state     = h_region;
      out_d.v_state     = v_region;
      out_d.disp_en     = (h_region == ST_ACTIVE) && (v_region == ST_ACTIVE);
      out_d.pix_x       = h_coord;
      out_d.pix_y       = v_coord;
      out_d.cell_x      = out_d.disp_en ? h_cell : 3'd0;
      out_d.cell_y      = (v_region == ST_ACTIVE) ? v_cell : 3'd0;
      out_d.frame_start = (h_count == '0) && (v_count == '0) && !pix_en_q;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         pix_en_q <= 1'b0;
         out_q    <= OUT_RST;
      end else begin
         pix_en_q <= ~pix_en_q;
         out_q    <= out_d;
      end
   end

   assign PIX_EN      = pix_en_q;
   assign VGA_HS      = out_q.hs;
   assign VGA_VS      = out_q.vs;
   assign H_STATE     = out_q.h_state;
   assign V_STATE     = out_q.v_state;
   assign DISP_EN     = out_q.disp_en;
   assign PIX_X       = out_q.pix_x;
   assign PIX_Y       = out_q.pix_y;
   assign CELL_X      = out_q.cell_x;
   assign CELL_Y      = out_q.cell_y;
   assign FRAME_START = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for line timing and a
// short-frame instance (23 lines, 2-line cells) so full frames fit a short run.
module tb_vga_timing_gen;

   logic       clk;
   logic       rst_n;

   logic       d_pe, d_hs, d_vs, d_de, d_fs;
   logic [1:0] d_hst, d_vst;
   logic [9:0] d_px, d_py;
   logic [2:0] d_cx, d_cy;

   logic       s_pe, s_hs, s_vs, s_de, s_fs;
   logic [1:0] s_hst, s_vst;
   logic [9:0] s_px, s_py;
   logic [2:0] s_cx, s_cy;

   int checks = 0;
   int errors = 0;
   int k;

   int d_hs_low, d_vs_low, d_fs_cnt;
   int s_hs_low, s_vs_low, s_de_cnt, s_de_lines, s_fs_cnt, s_fs_first, s_fs_last, s_py_max;
   logic s_de_prev;
   logic pe_seen;

   vga_timing_gen u_dut (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .PIX_EN      (d_pe),
      .VGA_HS      (d_hs),
      .VGA_VS      (d_vs),
      .H_STATE     (d_hst),
      .V_STATE     (d_vst),
      .DISP_EN     (d_de),
      .PIX_X       (d_px),
      .PIX_Y       (d_py),
      .CELL_X      (d_cx),
      .CELL_Y      (d_cy),
      .FRAME_START (d_fs)
   );

   vga_timing_gen #(
      .V_SYNC   (2),
      .V_BACK   (3),
      .V_ACTIVE (16),
      .V_FRONT  (2),
      .CELL_H   (2)
   ) u_small (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .PIX_EN      (s_pe),
      .VGA_HS      (s_hs),
      .VGA_VS      (s_vs),
      .H_STATE     (s_hst),
      .V_STATE     (s_vst),
      .DISP_EN     (s_de),
      .PIX_X       (s_px),
      .PIX_Y       (s_py),
      .CELL_X      (s_cx),
      .CELL_Y      (s_cy),
      .FRAME_START (s_fs)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      d_hs_low = 0; d_vs_low = 0; d_fs_cnt = 0;
      s_hs_low = 0; s_vs_low = 0; s_de_cnt = 0; s_de_lines = 0;
      s_fs_cnt = 0; s_fs_first = 0; s_fs_last = 0; s_py_max = 0;
      s_de_prev = 1'b0;
   endtask

   // k counts clocks after the release edge; sample k is taken on the falling edge after it.
   task automatic advance();
      @(negedge clk);
      k++;
      if (!d_hs) d_hs_low++;
      if (!d_vs) d_vs_low++;
      if (d_fs)  d_fs_cnt++;
      if (!s_hs) s_hs_low++;
      if (!s_vs) s_vs_low++;
      if (s_de)  s_de_cnt++;
      if (s_de && !s_de_prev) s_de_lines++;
      s_de_prev = s_de;
      if (s_fs) begin
         s_fs_cnt++;
         if (s_fs_cnt == 1) s_fs_first = k;
         s_fs_last = k;
      end
      if (int'(s_py) > s_py_max) s_py_max = int'(s_py);
   endtask

   task automatic run_to(input int target);
      while (k < target) advance();
   endtask

   initial begin
      // Reset held for 10 clocks
      rst_n   = 1'b0;
      pe_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (d_pe) pe_seen = 1'b1;
      end
      check("rst_pix_en_never_high", pe_seen, 0);
      check("rst_hs", d_hs, 1);
      check("rst_vs", d_vs, 1);
      check("rst_h_state", d_hst, 0);
      check("rst_v_state", d_vst, 0);
      check("rst_disp_en", d_de, 0);
      check("rst_pix_x", d_px, 0);
      check("rst_pix_y", d_py, 0);
      check("rst_cell_x", d_cx, 0);
      check("rst_cell_y", d_cy, 0);
      check("rst_frame_start", d_fs, 0);

      rst_n = 1'b1;
      k = -1;
      clear_stats();

      // Release: first edge shows (0,0) with FRAME_START
      run_to(0);
      check("rel_pix_en_k0", d_pe, 1);
      check("rel_frame_start_k0", d_fs, 1);
      check("rel_hs_k0", d_hs, 0);
      check("rel_h_state_k0", d_hst, 0);
      run_to(1);
      check("rel_pix_en_k1", d_pe, 0);
      check("rel_frame_start_k1", d_fs, 0);
      check("rel_hs_k1", d_hs, 0);

      // Two lines of horizontal timing on the default instance
      run_to(191);  check("h_state_k191", d_hst, 0);
      run_to(192);  check("h_state_k192", d_hst, 1);
                    check("hs_k192", d_hs, 1);
      run_to(287);  check("h_state_k287", d_hst, 1);
      run_to(288);  check("h_state_k288", d_hst, 2);
                    check("pix_x_k288", d_px, 0);
                    check("disp_en_vsync_line", d_de, 0);
      run_to(446);  check("pix_x_79", d_px, 79);
                    check("cell_x_vblank", s_cx, 0);
      run_to(448);  check("pix_x_80", d_px, 80);
      run_to(1566); check("pix_x_639", d_px, 639);
      run_to(1567); check("h_state_k1567", d_hst, 2);
      run_to(1568); check("h_state_k1568", d_hst, 3);
                    check("pix_x_front", d_px, 0);
      run_to(1599); check("h_state_k1599", d_hst, 3);
                    check("hs_k1599", d_hs, 1);
      run_to(1600); check("h_state_k1600", d_hst, 0);
                    check("hs_k1600", d_hs, 0);
                    check("v_state_after_hwrap", d_vst, 0);
      run_to(1791); check("hs_k1791", d_hs, 0);
      run_to(1792); check("hs_k1792", d_hs, 1);
      run_to(3199); check("hs_low_clocks_2lines", d_hs_low, 384);
                    check("vs_low_clocks", d_vs_low, 3200);
                    check("frame_start_2lines", d_fs_cnt, 1);
                    check("vs_k3199", d_vs, 0);
                    check("s_v_state_k3199", s_vst, 0);
      run_to(3200); check("vs_k3200", d_vs, 1);
                    check("v_state_k3200", d_vst, 1);
                    check("s_v_state_k3200", s_vst, 1);

      // Short-frame instance: first active line is line 5 (k 8000..9599)
      run_to(7999); check("s_v_state_k7999", s_vst, 1);
      run_to(8000); check("s_v_state_k8000", s_vst, 2);
      run_to(8200); check("s_cell_x_hback", s_cx, 0);
      run_to(8287); check("s_disp_en_k8287", s_de, 0);
      run_to(8288); check("s_disp_en_k8288", s_de, 1);
                    check("s_pix_y_line5", s_py, 0);
                    check("s_cell_y_line5", s_cy, 0);
                    check("s_cell_x_px0", s_cx, 0);
      run_to(8446); check("s_cell_x_px79", s_cx, 0);
      run_to(8448); check("s_cell_x_px80", s_cx, 1);
      run_to(9566); check("s_cell_x_px639", s_cx, 7);
                    check("s_pix_x_639", s_px, 639);
      run_to(9567); check("s_disp_en_k9567", s_de, 1);
      run_to(9568); check("s_disp_en_k9568", s_de, 0);
                    check("s_cell_x_hfront", s_cx, 0);
      run_to(10400); check("s_pix_y_1", s_py, 1);
                     check("s_cell_y_py1", s_cy, 0);
      run_to(12000); check("s_pix_y_2", s_py, 2);
                     check("s_cell_y_py2", s_cy, 1);
      run_to(32800); check("s_pix_y_15", s_py, 15);
                     check("s_cell_y_py15", s_cy, 7);
      run_to(34400); check("s_v_state_vfront", s_vst, 3);
                     check("s_pix_y_vfront", s_py, 0);
                     check("s_cell_y_vfront", s_cy, 0);
                     check("s_disp_en_vfront", s_de, 0);

      // Frame wrap at (799, 22)
      run_to(36798); check("wrap_h_state_before", s_hst, 3);
                     check("wrap_v_state_before", s_vst, 3);
                     check("wrap_fs_before", s_fs, 0);
      run_to(36799); check("frame_vs_low_clocks", s_vs_low, 3200);
                     check("frame_disp_en_clocks", s_de_cnt, 16 * 1280);
                     check("frame_disp_en_lines", s_de_lines, 16);
                     check("frame_pix_y_max", s_py_max, 15);
                     check("frame_fs_count", s_fs_cnt, 1);
      run_to(36800); check("wrap_fs", s_fs, 1);
                     check("wrap_h_state", s_hst, 0);
                     check("wrap_v_state", s_vst, 0);
                     check("wrap_vs", s_vs, 0);
      run_to(36801); check("wrap_fs_one_clock", s_fs, 0);
                     check("frame_fs_count_2", s_fs_cnt, 2);
                     check("frame_period", s_fs_last - s_fs_first, 36800);
      run_to(39999); check("wrap_no_extra_vstep", s_vst, 0);
      run_to(40000); check("wrap_v_back_line2", s_vst, 1);

      // Reset mid-frame at line 10, h_cnt 400 of the second frame
      run_to(53600); check("mid_h_state_pre", s_hst, 2);
                     check("mid_disp_en_pre", s_de, 1);
                     check("mid_pix_x_pre", s_px, 256);
                     check("mid_pix_y_pre", s_py, 5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_h_state", s_hst, 0);
      check("mid_rst_v_state", s_vst, 0);
      check("mid_rst_disp_en", s_de, 0);
      check("mid_rst_pix_x", s_px, 0);
      check("mid_rst_pix_y", s_py, 0);
      check("mid_rst_cell_x", s_cx, 0);
      check("mid_rst_cell_y", s_cy, 0);
      check("mid_rst_hs", s_hs, 1);
      check("mid_rst_vs", s_vs, 1);
      check("mid_rst_pix_en", s_pe, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      k = -1;
      clear_stats();

      run_to(0);    check("re_fs_k0", s_fs, 1);
                    check("re_pix_en_k0", s_pe, 1);
      run_to(1);    check("re_fs_k1", s_fs, 0);
      run_to(191);  check("re_h_state_k191", s_hst, 0);
      run_to(192);  check("re_h_state_k192", s_hst, 1);
      run_to(288);  check("re_h_state_k288", s_hst, 2);
      run_to(1568); check("re_h_state_k1568", s_hst, 3);
      run_to(1599); check("re_hs_low_clocks", s_hs_low, 192);
                    check("re_fs_count", s_fs_cnt, 1);
      run_to(1600); check("re_h_state_k1600", s_hst, 0);
                    check("re_hs_k1600", s_hs, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
